// File: rtl/thermo_slew_pkg.sv
// Shared constants, FSM encoding and the binary-to-thermometer helper for the
// thermometer slew controller.
package thermo_slew_pkg;

   localparam int TS_N_ARRAY = 47;
   localparam int TS_CODE_W  = 6;
   localparam int TS_DIV_W   = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SLEW = 1'b1
   } ts_state_e;

   localparam logic [0:0] S_IDLE = IDLE;
   localparam logic [0:0] S_SLEW = SLEW;

   // Bit i is set iff i < code.
   function automatic logic [TS_N_ARRAY-1:0] bin2therm(input logic [TS_CODE_W-1:0] code);
      logic [TS_N_ARRAY-1:0] therm;
      for (int i = 0; i < TS_N_ARRAY; i++) begin
         therm[i] = (i < int'(code));
      end
      return therm;
   endfunction

endpackage

// File: rtl/thermo_slew_ctrl_step_tick_gen.sv
// Step prescaler: emits one tick every (div+1) enabled cycles, restarted by a
// synchronous clear that also latches the divider value.
module step_tick_gen
   import thermo_slew_pkg::*;
#(
   parameter int DIV_W = TS_DIV_W
)
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_cnt;

   // Down-counter loaded with div; terminal count at zero reloads it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div <= '0;
         r_cnt <= '0;
      end else if (i_clear) begin
         r_div <= i_div;
         r_cnt <= i_div;
      end else if (i_enable) begin
         if (r_cnt == '0) begin
            r_cnt <= r_div;
         end else begin
            r_cnt <= r_cnt - DIV_W'(1);
         end
      end
   end

   assign o_tick = i_enable && (r_cnt == '0);

endmodule

// File: rtl/thermo_slew_ctrl.sv
// Slews the switch-array thermometer bus one unit cell per step toward an
// accepted binary target code, at a rate set by the latched step divider.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | ready for a new code; ctrl holds at cur_code
//   S_SLEW | stepping cur_code toward target on each divider tick
module thermo_slew_ctrl
   import thermo_slew_pkg::*;
#(
   parameter int N_ARRAY = TS_N_ARRAY,
   parameter int CODE_W  = TS_CODE_W,
   parameter int DIV_W   = TS_DIV_W
)
(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [CODE_W-1:0]  i_code_in,
   input  logic               i_code_valid,
   output logic               o_code_ready,
   input  logic [DIV_W-1:0]   i_step_div,
   output logic [N_ARRAY-1:0] o_ctrl,
   output logic [CODE_W-1:0]  o_cur_code,
   output logic               o_busy,
   output logic               o_sat_err
);

   localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(N_ARRAY);

   logic [0:0]         r_state;
   logic [CODE_W-1:0]  r_cur_code;
   logic [CODE_W-1:0]  r_target;
   logic [N_ARRAY-1:0] r_ctrl;
   logic               r_ready;
   logic               r_sat_err;

   logic               w_accept;
   logic               w_over;
   logic [CODE_W-1:0]  w_clamped;
   logic               w_slewing;
   logic               w_tick;
   logic [CODE_W-1:0]  w_next_code;
   logic               w_arrive;

   assign w_slewing   = (r_state == S_SLEW);
   assign w_accept    = i_code_valid && r_ready && (r_state == S_IDLE);
   assign w_over      = (i_code_in > MAX_CODE);
   assign w_clamped   = w_over ? MAX_CODE : i_code_in;
   assign w_next_code = (r_cur_code < r_target) ? (r_cur_code + CODE_W'(1))
                                                : (r_cur_code - CODE_W'(1));
   assign w_arrive    = (w_next_code == r_target);

   step_tick_gen #(
      .DIV_W (DIV_W)
   ) u_step_tick_gen (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clear  (w_accept),
      .i_enable (w_slewing),
      .i_div    (i_step_div),
      .o_tick   (w_tick)
   );

   // Ready is registered so it stays low through reset and rises one cycle
   // after release, and so it rises on the same edge as the final step.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_cur_code <= '0;
         r_target   <= '0;
         r_ctrl     <= '0;
         r_ready    <= 1'b0;
         r_sat_err  <= 1'b0;
      end else begin
         r_sat_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_ready <= 1'b1;
               if (w_accept) begin
                  r_target  <= w_clamped;
                  r_sat_err <= w_over;
                  if (w_clamped != r_cur_code) begin
                     r_state <= S_SLEW;
                     r_ready <= 1'b0;
                  end
               end
            end
            S_SLEW: begin
               if (w_tick) begin
                  r_cur_code <= w_next_code;
                  r_ctrl     <= bin2therm(w_next_code);
                  if (w_arrive) begin
                     r_state <= S_IDLE;
                     r_ready <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign o_code_ready = r_ready;
   assign o_ctrl       = r_ctrl;
   assign o_cur_code   = r_cur_code;
   assign o_busy       = w_slewing;
   assign o_sat_err    = r_sat_err;

endmodule

// File: tb/tb_thermo_slew_ctrl.sv
// Directed bench for thermo_slew_ctrl: reset, up/down slew, saturation,
// no-op accept, backpressure during slew and reset mid-slew.
module tb_thermo_slew_ctrl;

   logic        clk;
   logic        rst_n;
   logic [5:0]  code_in;
   logic        code_valid;
   logic        code_ready;
   logic [7:0]  step_div;
   logic [46:0] ctrl;
   logic [5:0]  cur_code;
   logic        busy;
   logic        sat_err;

   int checks = 0;
   int errors = 0;

   thermo_slew_ctrl dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_code_in    (code_in),
      .i_code_valid (code_valid),
      .o_code_ready (code_ready),
      .i_step_div   (step_div),
      .o_ctrl       (ctrl),
      .o_cur_code   (cur_code),
      .o_busy       (busy),
      .o_sat_err    (sat_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [46:0] therm(input int n);
      logic [46:0] t;
      for (int i = 0; i < 47; i++) t[i] = (i < n);
      return t;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input int exp_code, input logic exp_busy);
      check({tag, " cur_code"}, 64'(cur_code), 64'(exp_code));
      check({tag, " ctrl"}, 64'(ctrl), 64'(therm(exp_code)));
      check({tag, " busy"}, 64'(busy), 64'(exp_busy));
   endtask

   // Present a code for exactly one accept edge; returns just after that edge.
   task automatic accept(input int code, input int div);
      code_in    = 6'(code);
      step_div   = 8'(div);
      code_valid = 1'b1;
      step();
      code_valid = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      code_in    = '0;
      code_valid = 1'b0;
      step_div   = '0;

      // Reset
      step();
      step();
      check_state("reset", 0, 1'b0);
      check("reset ready", 64'(code_ready), 64'(0));
      check("reset sat_err", 64'(sat_err), 64'(0));
      rst_n = 1'b1;
      step();
      check("ready after release", 64'(code_ready), 64'(1));

      // Up-slew 0 -> 47, one step per cycle
      accept(47, 0);
      check_state("up accept", 0, 1'b1);
      check("up accept ready", 64'(code_ready), 64'(0));
      for (int c = 1; c <= 47; c++) begin
         step();
         check_state("up slew", c, (c < 47));
         check("up sat_err", 64'(sat_err), 64'(0));
      end
      check("up done ready", 64'(code_ready), 64'(1));

      // Down-slew 47 -> 10, one step per 4 cycles
      accept(10, 3);
      for (int c = 1; c <= 148; c++) begin
         step();
         check_state("down slew", 47 - c / 4, (c < 148));
      end
      check("down final ctrl", 64'(ctrl), 64'h3FF);
      check("down done ready", 64'(code_ready), 64'(1));

      // Back to 0, then saturating request of 60
      accept(0, 0);
      for (int c = 1; c <= 10; c++) step();
      check_state("to zero", 0, 1'b0);
      accept(60, 0);
      check("sat pulse", 64'(sat_err), 64'(1));
      step();
      check("sat pulse width", 64'(sat_err), 64'(0));
      check_state("sat first step", 1, 1'b1);
      for (int c = 2; c <= 47; c++) step();
      check_state("sat final", 47, 1'b0);
      check("sat final ready", 64'(code_ready), 64'(1));

      // No-op accepts at cur_code, including one that clamps onto it
      accept(47, 0);
      check("noop busy", 64'(busy), 64'(0));
      check("noop ready", 64'(code_ready), 64'(1));
      check("noop sat_err", 64'(sat_err), 64'(0));
      accept(63, 0);
      check("noop clamp sat_err", 64'(sat_err), 64'(1));
      check_state("noop clamp", 47, 1'b0);
      step();
      check("noop clamp pulse width", 64'(sat_err), 64'(0));

      // Backpressure: 47 -> 40 at div 1 while 5 is held on the input
      accept(40, 1);
      code_in    = 6'd5;
      step_div   = 8'd0;
      code_valid = 1'b1;
      step();
      check_state("bp k+1", 47, 1'b1);
      step();
      check_state("bp k+2", 46, 1'b1);
      step();
      check_state("bp latched div", 46, 1'b1);
      check("bp ready low", 64'(code_ready), 64'(0));
      for (int c = 4; c <= 14; c++) step();
      check_state("bp arrive", 40, 1'b0);
      check("bp ready rise", 64'(code_ready), 64'(1));
      step();
      code_valid = 1'b0;
      check_state("bp second accept", 40, 1'b1);
      check("bp second ready", 64'(code_ready), 64'(0));
      for (int c = 1; c <= 35; c++) step();
      check_state("bp final", 5, 1'b0);

      // Reset mid-slew toward 40, asserted once cur_code reaches 20
      accept(40, 0);
      for (int c = 1; c <= 15; c++) step();
      check_state("pre reset", 20, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_state("async reset", 0, 1'b0);
      check("async reset ready", 64'(code_ready), 64'(0));
      step();
      step();
      rst_n = 1'b1;
      step();
      check("post reset ready", 64'(code_ready), 64'(1));
      for (int c = 1; c <= 10; c++) step();
      check_state("no residual slew", 0, 1'b0);

      // Divider restarts cleanly after reset
      accept(3, 2);
      step();
      step();
      check_state("restart k+2", 0, 1'b1);
      step();
      check_state("restart k+3", 1, 1'b1);
      for (int c = 4; c <= 9; c++) step();
      check_state("restart final", 3, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
